// File: rtl/param_register_file_if.sv
// Bus bundle for param_register_file: write, PC-load, read and scoreboard signals.
// The master modport drives the register file; the slave modport is the register file.
interface param_register_file_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned NREGS  = 16,
  parameter int unsigned ADDR_W = 4
);
  logic              RFLd;
  logic [ADDR_W-1:0] C;
  logic [DATA_W-1:0] PW;
  logic              HZPCld;
  logic [DATA_W-1:0] PCin;
  logic [ADDR_W-1:0] SA;
  logic [ADDR_W-1:0] SB;
  logic [ADDR_W-1:0] SD;
  logic [2:0]        RDV;
  logic              RSV;
  logic [ADDR_W-1:0] RSV_A;
  logic [DATA_W-1:0] PA;
  logic [DATA_W-1:0] PB;
  logic [DATA_W-1:0] PD;
  logic [DATA_W-1:0] PCout;
  logic              HAZ;
  logic [NREGS-1:0]  BUSY;

  modport master (
    output RFLd, C, PW, HZPCld, PCin, SA, SB, SD, RDV, RSV, RSV_A,
    input  PA, PB, PD, PCout, HAZ, BUSY
  );

  modport slave (
    input  RFLd, C, PW, HZPCld, PCin, SA, SB, SD, RDV, RSV, RSV_A,
    output PA, PB, PD, PCout, HAZ, BUSY
  );
endinterface

// File: rtl/param_register_file.sv
// 3-read/1-write register file with in-file PC register and pending-write scoreboard.
// Optional feature macro WRITE_BYPASS_EN: forward PW to matching read ports and HAZ.
module param_register_file #(
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       NREGS    = 16,
  parameter int unsigned       ADDR_W   = 4,
  parameter int unsigned       PC_IDX   = 15,
  parameter logic [DATA_W-1:0] RESET_PC = '0
) (
  input logic                 CLK,
  input logic                 RST,
  param_register_file_if.slave rf
);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic [NREGS-1:0]  busy_q, busy_d;
  logic [NREGS-1:0]  wr_hit, rsv_hit, busy_eff;
  logic [ADDR_W-1:0] sel    [3];
  logic [DATA_W-1:0] rdata  [3];
  logic [2:0]        sel_busy;

  // Per-register decode; selects >= NREGS never match, so they are ignored.
  always_comb begin
    wr_hit  = '0;
    rsv_hit = '0;
    for (int unsigned i = 0; i < NREGS; i++) begin
      wr_hit[i]  = rf.RFLd && (rf.C == ADDR_W'(i));
      rsv_hit[i] = rf.RSV && (rf.RSV_A == ADDR_W'(i));
    end
  end

  always_comb begin
    regs_d = regs_q;
    // A reserve on the same edge as a writeback wins: the newer producer owns the register.
    busy_d = (busy_q & ~wr_hit) | rsv_hit;
    if (rf.HZPCld) begin
      regs_d[PC_IDX] = rf.PCin;
    end
    for (int unsigned i = 0; i < NREGS; i++) begin
      if (wr_hit[i]) begin
        regs_d[i] = rf.PW;
      end
    end
    if (RST) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs_d[i] = (i == PC_IDX) ? RESET_PC : '0;
      end
      busy_d = '0;
    end
  end

  always_ff @(posedge CLK) begin
    regs_q <= regs_d;
    busy_q <= busy_d;
  end

`ifdef WRITE_BYPASS_EN
  assign busy_eff = busy_q & ~(wr_hit & ~rsv_hit);
`else
  assign busy_eff = busy_q;
`endif

  always_comb begin
    sel[0] = rf.SA;
    sel[1] = rf.SB;
    sel[2] = rf.SD;
    for (int unsigned p = 0; p < 3; p++) begin
      rdata[p]    = '0;
      sel_busy[p] = 1'b0;
      for (int unsigned i = 0; i < NREGS; i++) begin
        if (sel[p] == ADDR_W'(i)) begin
          rdata[p]    = regs_q[i];
          sel_busy[p] = busy_eff[i];
`ifdef WRITE_BYPASS_EN
          if (wr_hit[i]) begin
            rdata[p] = rf.PW;
          end
`endif
        end
      end
    end
  end

  assign rf.PA    = rdata[0];
  assign rf.PB    = rdata[1];
  assign rf.PD    = rdata[2];
  assign rf.PCout = regs_q[PC_IDX];
  assign rf.HAZ   = |(rf.RDV & sel_busy);
  assign rf.BUSY  = busy_q;

endmodule

// File: tb/tb_param_register_file.sv
// Self-checking bench for param_register_file: expected values are queued at drive time
// and popped when the corresponding output is sampled.
module tb_param_register_file;
  localparam int unsigned DW  = 32;
  localparam int unsigned NR  = 14;
  localparam int unsigned AW  = 4;
  localparam int unsigned PCI = 13;
  localparam logic [31:0] RPC = 32'h0000_0100;
`ifdef WRITE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic CLK = 1'b0;
  logic RST;

  param_register_file_if #(.DATA_W(DW), .NREGS(NR), .ADDR_W(AW)) rf ();

  param_register_file #(
    .DATA_W  (DW),
    .NREGS   (NR),
    .ADDR_W  (AW),
    .PC_IDX  (PCI),
    .RESET_PC(RPC)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .rf (rf)
  );

  always #5 CLK = ~CLK;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] sb_q [$];
  logic [31:0] exp_v;
  logic [31:0] m [NR];

  task automatic idle();
    rf.RFLd = 1'b0; rf.C = '0; rf.PW = '0; rf.HZPCld = 1'b0; rf.PCin = '0;
    rf.SA = '0; rf.SB = '0; rf.SD = '0; rf.RDV = '0; rf.RSV = 1'b0; rf.RSV_A = '0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NR; i++) m[i] = (i == PCI) ? RPC : 32'h0;
  endtask

  task automatic test_reset();
    idle();
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    model_reset();
    for (int s = 0; s < 16; s++) begin
      rf.SA = AW'(s); rf.SB = AW'(s); rf.SD = AW'(s);
      for (int k = 0; k < 3; k++) sb_q.push_back(s < NR ? m[s] : 32'h0);
      #1;
      exp_v = sb_q.pop_front(); n_vec++;
      if (rf.PA !== exp_v) begin n_err++; $display("FAIL reset_pa[%0d]: got %h expected %h", s, rf.PA, exp_v); end
      exp_v = sb_q.pop_front(); n_vec++;
      if (rf.PB !== exp_v) begin n_err++; $display("FAIL reset_pb[%0d]: got %h expected %h", s, rf.PB, exp_v); end
      exp_v = sb_q.pop_front(); n_vec++;
      if (rf.PD !== exp_v) begin n_err++; $display("FAIL reset_pd[%0d]: got %h expected %h", s, rf.PD, exp_v); end
      @(negedge CLK);
    end
    rf.RDV = 3'b111;
    sb_q.push_back(RPC); sb_q.push_back(32'h0); sb_q.push_back(32'h0);
    #1;
    exp_v = sb_q.pop_front(); n_vec++;
    if (rf.PCout !== exp_v) begin n_err++; $display("FAIL reset_pcout: got %h expected %h", rf.PCout, exp_v); end
    exp_v = sb_q.pop_front(); n_vec++;
    if (rf.BUSY !== exp_v[NR-1:0]) begin n_err++; $display("FAIL reset_busy: got %h expected %h", rf.BUSY, exp_v[NR-1:0]); end
    exp_v = sb_q.pop_front(); n_vec++;
    if (rf.HAZ !== exp_v[0]) begin n_err++; $display("FAIL reset_haz: got %b expected %b", rf.HAZ, exp_v[0]); end
    @(negedge CLK);
  endtask

  task automatic test_write_read();
    idle();
    rf.RFLd = 1'b1; rf.C = 4'd3; rf.PW = 32'd90; rf.SA = 4'd3;
    sb_q.push_back(BYP ? 32'd90 : m[3]);
    #1;
    exp_v = sb_q.pop_front(); n_vec++;
    if (rf.PA !== exp_v) begin n_err++; $display("FAIL wr_same_cycle: got %h expected %h", rf.PA, exp_v); end
    m[3] = 32'd90;
    @(negedge CLK);
    rf.RFLd = 1'b0;
    sb_q.push_back(32'd90);
    #1;
    exp_v = sb_q.pop_front(); n_vec++;
    if (rf.PA !== exp_v) begin n_err++; $display("FAIL wr_next_cycle: got %h expected %h", rf.PA, exp_v); end
    // Out-of-range write must be dropped; out-of-range read returns zero.
    rf.RFLd = 1'b1; rf.C = 4'd14; rf.PW = 32'hDEAD_BEEF; rf.SB = 4'd14;
    sb_q.push_back(32'h0);
    #1;
    exp_v = sb_q.pop_front(); n_vec++;
    if (rf.PB !== exp_v) begin n_err++; $display("FAIL oor_read: got %h expected %h", rf.PB, exp_v); end
    @(negedge CLK);
    idle();
    for (int s = 0; s < 16; s++) begin
      rf.SD = AW'(s);
      sb_q.push_back(s < NR ? m[s] : 32'h0);
      #1;
      exp_v = sb_q.pop_front(); n_vec++;
      if (rf.PD !== exp_v) begin n_err++; $display("FAIL oor_write_sweep[%0d]: got %h expected %h", s, rf.PD, exp_v); end
      @(negedge CLK);
    end
  endtask

  task automatic test_pc();
    logic [31:0] pcs [3] = '{32'd0, 32'd4, 32'd8};
    idle();
    foreach (pcs[k]) begin
      rf.HZPCld = 1'b1; rf.PCin = pcs[k];
      m[PCI] = pcs[k];
      sb_q.push_back(pcs[k]);
      @(negedge CLK);
      #1;
      exp_v = sb_q.pop_front(); n_vec++;
      if (rf.PCout !== exp_v) begin n_err++; $display("FAIL pc_track[%0d]: got %h expected %h", k, rf.PCout, exp_v); end
    end
    rf.HZPCld = 1'b0; rf.PCin = 32'd12; rf.SA = AW'(PCI);
    for (int k = 0; k < 2; k++) begin
      sb_q.push_back(32'd8); sb_q.push_back(32'd8);
      @(negedge CLK);
      #1;
      exp_v = sb_q.pop_front(); n_vec++;
      if (rf.PCout !== exp_v) begin n_err++; $display("FAIL pc_hold[%0d]: got %h expected %h", k, rf.PCout, exp_v); end
      exp_v = sb_q.pop_front(); n_vec++;
      if (rf.PA !== exp_v) begin n_err++; $display("FAIL pc_read_port[%0d]: got %h expected %h", k, rf.PA, exp_v); end
    end
  endtask

  task automatic test_pc_priority();
    idle();
    rf.RFLd = 1'b1; rf.C = AW'(PCI); rf.PW = 32'd35; rf.HZPCld = 1'b1; rf.PCin = 32'd100;
    m[PCI] = 32'd35;
    sb_q.push_back(32'd35);
    @(negedge CLK);
    #1;
    exp_v = sb_q.pop_front(); n_vec++;
    if (rf.PCout !== exp_v) begin n_err++; $display("FAIL pc_write_wins: got %h expected %h", rf.PCout, exp_v); end
    rf.C = 4'd2; rf.PW = 32'd55; rf.SB = 4'd2;
    m[PCI] = 32'd100; m[2] = 32'd55;
    sb_q.push_back(32'd100); sb_q.push_back(32'd55);
    @(negedge CLK);
    idle();
    rf.SB = 4'd2;
    #1;
    exp_v = sb_q.pop_front(); n_vec++;
    if (rf.PCout !== exp_v) begin n_err++; $display("FAIL pc_load_with_gpr_write: got %h expected %h", rf.PCout, exp_v); end
    exp_v = sb_q.pop_front(); n_vec++;
    if (rf.PB !== exp_v) begin n_err++; $display("FAIL gpr_write_with_pc_load: got %h expected %h", rf.PB, exp_v); end
    @(negedge CLK);
  endtask

  task automatic test_scoreboard();
    idle();
    rf.RSV = 1'b1; rf.RSV_A = 4'd5;
    sb_q.push_back(32'h20); sb_q.push_back(32'h1); sb_q.push_back(32'h0);
    @(negedge CLK);
    idle();
    rf.SB = 4'd5; rf.RDV = 3'b010;
    #1;
    exp_v = sb_q.pop_front(); n_vec++;
    if (rf.BUSY !== exp_v[NR-1:0]) begin n_err++; $display("FAIL sb_set_busy: got %h expected %h", rf.BUSY, exp_v[NR-1:0]); end
    exp_v = sb_q.pop_front(); n_vec++;
    if (rf.HAZ !== exp_v[0]) begin n_err++; $display("FAIL sb_haz_b: got %b expected %b", rf.HAZ, exp_v[0]); end
    rf.RDV = 3'b101;
    #1;
    exp_v = sb_q.pop_front(); n_vec++;
    if (rf.HAZ !== exp_v[0]) begin n_err++; $display("FAIL sb_haz_masked: got %b expected %b", rf.HAZ, exp_v[0]); end
    rf.RDV = 3'b010; rf.RFLd = 1'b1; rf.C = 4'd5; rf.PW = 32'd7;
    sb_q.push_back(BYP ? 32'h0 : 32'h1); sb_q.push_back(BYP ? 32'd7 : m[5]);
    #1;
    exp_v = sb_q.pop_front(); n_vec++;
    if (rf.HAZ !== exp_v[0]) begin n_err++; $display("FAIL sb_haz_wb_cycle: got %b expected %b", rf.HAZ, exp_v[0]); end
    exp_v = sb_q.pop_front(); n_vec++;
    if (rf.PB !== exp_v) begin n_err++; $display("FAIL sb_pb_wb_cycle: got %h expected %h", rf.PB, exp_v); end
    m[5] = 32'd7;
    sb_q.push_back(32'h0); sb_q.push_back(32'h0); sb_q.push_back(32'd7);
    @(negedge CLK);
    rf.RFLd = 1'b0;
    #1;
    exp_v = sb_q.pop_front(); n_vec++;
    if (rf.HAZ !== exp_v[0]) begin n_err++; $display("FAIL sb_haz_after_wb: got %b expected %b", rf.HAZ, exp_v[0]); end
    exp_v = sb_q.pop_front(); n_vec++;
    if (rf.BUSY !== exp_v[NR-1:0]) begin n_err++; $display("FAIL sb_busy_after_wb: got %h expected %h", rf.BUSY, exp_v[NR-1:0]); end
    exp_v = sb_q.pop_front(); n_vec++;
    if (rf.PB !== exp_v) begin n_err++; $display("FAIL sb_pb_after_wb: got %h expected %h", rf.PB, exp_v); end
    // Port D hazard path.
    rf.RSV = 1'b1; rf.RSV_A = 4'd9;
    @(negedge CLK);
    idle();
    rf.SD = 4'd9; rf.RDV = 3'b100;
    sb_q.push_back(32'h1);
    #1;
    exp_v = sb_q.pop_front(); n_vec++;
    if (rf.HAZ !== exp_v[0]) begin n_err++; $display("FAIL sb_haz_d: got %b expected %b", rf.HAZ, exp_v[0]); end
    rf.RFLd = 1'b1; rf.C = 4'd9; rf.PW = 32'h99; rf.RDV = 3'b000;
    m[9] = 32'h99;
    @(negedge CLK);
  endtask

  task automatic test_set_clear();
    idle();
    rf.RSV = 1'b1; rf.RSV_A = 4'd5; rf.RFLd = 1'b1; rf.C = 4'd5; rf.PW = 32'h55;
    m[5] = 32'h55;
    sb_q.push_back(32'h20);
    @(negedge CLK);
    idle();
    rf.RSV = 1'b1; rf.RSV_A = 4'd14;
    #1;
    exp_v = sb_q.pop_front(); n_vec++;
    if (rf.BUSY !== exp_v[NR-1:0]) begin n_err++; $display("FAIL set_clear_same_edge: got %h expected %h", rf.BUSY, exp_v[NR-1:0]); end
    sb_q.push_back(32'h20);
    @(negedge CLK);
    idle();
    rf.SB = 4'd5; rf.RDV = 3'b010;
    #1;
    exp_v = sb_q.pop_front(); n_vec++;
    if (rf.BUSY !== exp_v[NR-1:0]) begin n_err++; $display("FAIL rsv_oor_ignored: got %h expected %h", rf.BUSY, exp_v[NR-1:0]); end
    RST = 1'b1; rf.HZPCld = 1'b1; rf.PCin = 32'h444; rf.RFLd = 1'b1; rf.C = 4'd2; rf.PW = 32'h1;
    sb_q.push_back(32'h1);
    #1;
    exp_v = sb_q.pop_front(); n_vec++;
    if (rf.HAZ !== exp_v[0]) begin n_err++; $display("FAIL haz_before_rst: got %b expected %b", rf.HAZ, exp_v[0]); end
    model_reset();
    sb_q.push_back(32'h0); sb_q.push_back(32'h0); sb_q.push_back(RPC); sb_q.push_back(32'h0);
    @(negedge CLK);
    RST = 1'b0;
    idle();
    rf.SB = 4'd5; rf.SA = 4'd2; rf.RDV = 3'b010;
    #1;
    exp_v = sb_q.pop_front(); n_vec++;
    if (rf.BUSY !== exp_v[NR-1:0]) begin n_err++; $display("FAIL rst_clears_busy: got %h expected %h", rf.BUSY, exp_v[NR-1:0]); end
    exp_v = sb_q.pop_front(); n_vec++;
    if (rf.HAZ !== exp_v[0]) begin n_err++; $display("FAIL rst_drops_haz: got %b expected %b", rf.HAZ, exp_v[0]); end
    exp_v = sb_q.pop_front(); n_vec++;
    if (rf.PCout !== exp_v) begin n_err++; $display("FAIL rst_over_pc_load: got %h expected %h", rf.PCout, exp_v); end
    exp_v = sb_q.pop_front(); n_vec++;
    if (rf.PA !== exp_v) begin n_err++; $display("FAIL rst_over_write: got %h expected %h", rf.PA, exp_v); end
    @(negedge CLK);
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] c, s;
    logic [31:0]   pw;
    idle();
    for (int k = 0; k < 40; k++) begin
      c  = AW'($urandom_range(0, NR - 1));
      s  = AW'($urandom_range(0, 15));
      pw = $urandom;
      rf.RFLd = 1'b1; rf.C = c; rf.PW = pw; rf.SA = s;
      sb_q.push_back(s >= AW'(NR) ? 32'h0 : ((BYP && c == s) ? pw : m[s]));
      #1;
      exp_v = sb_q.pop_front(); n_vec++;
      if (rf.PA !== exp_v) begin n_err++; $display("FAIL b2b[%0d] sel %0d: got %h expected %h", k, s, rf.PA, exp_v); end
      m[c] = pw;
      @(negedge CLK);
    end
    idle();
    for (int i = 0; i < NR; i++) begin
      rf.SB = AW'(i);
      sb_q.push_back(m[i]);
      #1;
      exp_v = sb_q.pop_front(); n_vec++;
      if (rf.PB !== exp_v) begin n_err++; $display("FAIL b2b_final[%0d]: got %h expected %h", i, rf.PB, exp_v); end
      @(negedge CLK);
    end
  endtask

  initial begin
    RST = 1'b1;
    idle();
    test_reset();
    test_write_read();
    test_pc();
    test_pc_priority();
    test_scoreboard();
    test_set_clear();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
